// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: icache fetch port, dcache load/store port and the single RAM port.
// The master modport is the arbiter's view; slave is the caches-plus-RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;

  logic              merr;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, merr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between instruction fetch and data load/store.
// Data has priority; a saturating starvation counter forces a fetch grant after STARVE_LIMIT data completions.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic           CLK,
  input logic           nRST,
  mem_arbiter_if.master bus
);

  localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);
  localparam logic [1:0]          RAM_ACCESS = 2'd2;
  localparam logic [1:0]          RAM_ERROR  = 2'd3;
  localparam logic [ADDR_W-1:0]   ADDR_ZERO  = '0;
  localparam logic [DATA_W-1:0]   DATA_ZERO  = '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  state_t              arb_pick;
  logic [STARVE_W-1:0] starve;
  logic [STARVE_W-1:0] starve_next;
  logic                dreq;
  logic                ram_done;
  logic                done_i;
  logic                done_d;
  logic                fetch_forced;

  assign dreq     = bus.dREN | bus.dWEN;
  assign ram_done = (state != IDLE) &&
                    ((bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR));
  assign done_i   = ram_done && (state == GNT_I);
  assign done_d   = ram_done && (state == GNT_D);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state  <= IDLE;
      starve <= '0;
    end else begin
      state  <= state_next;
      starve <= starve_next;
    end
  end

  // The forcing test uses the count including a data completion happening this cycle,
  // so exactly STARVE_LIMIT data completions go through before fetch wins.
  always_comb begin
    starve_next = starve;
    if (!bus.iREN) begin
      starve_next = '0;
    end else if (done_i) begin
      starve_next = '0;
    end else if (done_d && (starve != STARVE_MAX)) begin
      starve_next = starve + 1'b1;
    end
  end

  assign fetch_forced = (starve_next == STARVE_MAX);

  always_comb begin
    arb_pick = IDLE;
    if (dreq && bus.iREN && fetch_forced) begin
      arb_pick = GNT_I;
    end else if (dreq) begin
      arb_pick = GNT_D;
    end else if (bus.iREN) begin
      arb_pick = GNT_I;
    end
  end

  // Data keeps its priority across its own completions (bounded by starve); a completed
  // fetch never re-wins in its completion cycle, so only the data side is considered there.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        state_next = arb_pick;
      end
      GNT_I: begin
        if (done_i) begin
          state_next = dreq ? GNT_D : IDLE;
        end else if (!bus.iREN) begin
          state_next = IDLE;
        end
      end
      GNT_D: begin
        if (done_d) begin
          state_next = arb_pick;
        end else if (!dreq) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // RAM side is decoded from the grant only; a write wins over a simultaneous read.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = ADDR_ZERO;
    bus.ramstore = DATA_ZERO;
    case (state)
      GNT_I: begin
        bus.ramREN  = 1'b1;
        bus.ramaddr = bus.iaddr;
      end
      GNT_D: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      default: begin
        bus.ramREN = 1'b0;
      end
    endcase
  end

  assign bus.iwait = ~done_i;
  assign bus.dwait = ~done_d;
  assign bus.iload = bus.ramload;
  assign bus.dload = bus.ramload;
  assign bus.merr  = ram_done && (bus.ramstate == RAM_ERROR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a port-ownership reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them.
module tb_mem_arbiter;

  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int STARVE_LIMIT = 4;

  localparam logic [1:0] RS_FREE   = 2'd0;
  localparam logic [1:0] RS_BUSY   = 2'd1;
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam int OWN_NONE  = 0;
  localparam int OWN_FETCH = 1;
  localparam int OWN_DATA  = 2;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.master)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] store;
    logic        iwait;
    logic        dwait;
    logic        merr;
    logic [31:0] load;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks   = 0;
  int n_pass     = 0;
  int cyc        = 0;
  int owner      = OWN_NONE;
  int starve     = 0;
  int d_done_cnt = 0;
  int i_done_cnt = 0;

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] req, input int at_cycle);
    n_checks++;
    if (act === req) begin
      n_pass++;
    end else begin
      $display("[TB] FAIL %s (cycle %0d): got %0h, required %0h", name, at_cycle, act, req);
    end
  endtask

  // Expected outputs this cycle, from who owns the RAM port and what the caches/RAM present now.
  function automatic exp_t predict();
    exp_t e;
    logic completes;
    completes = (owner != OWN_NONE) && (bus.ramstate == RS_ACCESS || bus.ramstate == RS_ERROR);
    e.ren   = 1'b0;
    e.wen   = 1'b0;
    e.addr  = 32'h0;
    e.store = 32'h0;
    if (owner == OWN_FETCH) begin
      e.ren  = 1'b1;
      e.addr = bus.iaddr;
    end else if (owner == OWN_DATA) begin
      e.wen   = bus.dWEN;
      e.ren   = bus.dREN && !bus.dWEN;
      e.addr  = bus.daddr;
      e.store = bus.dstore;
    end
    e.iwait = !(completes && owner == OWN_FETCH);
    e.dwait = !(completes && owner == OWN_DATA);
    e.merr  = completes && (bus.ramstate == RS_ERROR);
    e.load  = bus.ramload;
    e.cyc   = cyc;
    return e;
  endfunction

  function automatic int choose(input logic want_d, input logic want_i, input int hungry);
    if (want_d && want_i && hungry == STARVE_LIMIT) return OWN_FETCH;
    if (want_d) return OWN_DATA;
    if (want_i) return OWN_FETCH;
    return OWN_NONE;
  endfunction

  // New owner at the clock edge: data first, fetch forced after STARVE_LIMIT data completions in a row.
  function automatic void advanceModel();
    logic completes;
    logic want_d;
    if (!nRST) begin
      owner  = OWN_NONE;
      starve = 0;
      return;
    end
    completes = (owner != OWN_NONE) && (bus.ramstate == RS_ACCESS || bus.ramstate == RS_ERROR);
    want_d    = bus.dREN || bus.dWEN;
    if (!bus.iREN) starve = 0;
    else if (completes && owner == OWN_FETCH) starve = 0;
    else if (completes && owner == OWN_DATA && starve < STARVE_LIMIT) starve = starve + 1;

    if (owner == OWN_NONE || (completes && owner == OWN_DATA)) begin
      owner = choose(want_d, bus.iREN, starve);
    end else if (completes) begin
      owner = want_d ? OWN_DATA : OWN_NONE;
    end else if (owner == OWN_FETCH && !bus.iREN) begin
      owner = OWN_NONE;
    end else if (owner == OWN_DATA && !want_d) begin
      owner = OWN_NONE;
    end
  endfunction

  task automatic applyStimulus(input logic rst_n, input logic iren, input logic [31:0] ia,
                               input logic dren, input logic dwen, input logic [31:0] da,
                               input logic [31:0] ds, input logic [1:0] rs, input logic [31:0] rl);
    nRST         = rst_n;
    bus.iREN     = iren;
    bus.iaddr    = ia;
    bus.dREN     = dren;
    bus.dWEN     = dwen;
    bus.daddr    = da;
    bus.dstore   = ds;
    bus.ramstate = rs;
    bus.ramload  = rl;
    exp_q.push_back(predict());
    @(posedge CLK);
    advanceModel();
    cyc++;
    #1;
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      checkOutput("ram_port", {62'b0, bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore},
                  {62'b0, mon_e.ren, mon_e.wen, mon_e.addr, mon_e.store}, mon_e.cyc);
      checkOutput("handshake", {125'b0, bus.iwait, bus.dwait, bus.merr},
                  {125'b0, mon_e.iwait, mon_e.dwait, mon_e.merr}, mon_e.cyc);
      checkOutput("iload", {96'b0, bus.iload}, {96'b0, mon_e.load}, mon_e.cyc);
      checkOutput("dload", {96'b0, bus.dload}, {96'b0, mon_e.load}, mon_e.cyc);
      if (bus.dwait === 1'b0) d_done_cnt++;
      if (bus.iwait === 1'b0) i_done_cnt++;
    end
  end

  always @(posedge CLK) begin
    if (nRST === 1'b1) begin
      assert (!(bus.dREN && bus.dWEN)) else $error("[TB] illegal dREN and dWEN together");
    end
  end

  initial begin
    logic        r_iren;
    logic        r_dren;
    logic        r_dwen;
    logic        r_rst;
    logic [1:0]  r_rs;
    logic [31:0] r_ia;
    logic [31:0] r_da;
    int          sel;

    bus.iREN = 1'b0; bus.iaddr = '0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.daddr = '0; bus.dstore = '0; bus.ramstate = RS_FREE; bus.ramload = '0;
    @(posedge CLK);
    #1;

    $display("[TB] reset with both caches requesting");
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, RS_ACCESS, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h40, 1'b1, 1'b0, 32'h100, 32'h0, RS_ACCESS, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0,  1'b0, 1'b0, 32'h0,   32'h0, RS_FREE,   32'h0);

    $display("[TB] lone fetch with two busy cycles");
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_BUSY,   32'h0);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_BUSY,   32'h0);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_BUSY,   32'h0);
    applyStimulus(1'b1, 1'b1, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_ACCESS, 32'h8C010004);
    applyStimulus(1'b1, 1'b0, 32'h40, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE,   32'h0);

    $display("[TB] fetch and load contend");
    applyStimulus(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0, RS_FREE,   32'h0);
    applyStimulus(1'b1, 1'b1, 32'h44, 1'b1, 1'b0, 32'h100, 32'h0, RS_ACCESS, 32'h11110000);
    applyStimulus(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h100, 32'h0, RS_FREE,   32'h0);
    applyStimulus(1'b1, 1'b1, 32'h44, 1'b0, 1'b0, 32'h100, 32'h0, RS_ACCESS, 32'h22220000);
    applyStimulus(1'b1, 1'b0, 32'h44, 1'b0, 1'b0, 32'h100, 32'h0, RS_FREE,   32'h0);

    $display("[TB] fetch held against a stream of stores");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
    d_done_cnt = 0;
    i_done_cnt = 0;
    for (int k = 0; k < 40 && i_done_cnt == 0; k++) begin
      applyStimulus(1'b1, 1'b1, 32'h500, 1'b0, 1'b1, 32'h600 + 32'(k), 32'(k), RS_ACCESS, 32'hA0 + 32'(k));
    end
    checkOutput("starve_fetch_served", {127'b0, i_done_cnt != 0}, {127'b0, 1'b1}, cyc);
    checkOutput("starve_data_count", 128'(d_done_cnt), 128'(STARVE_LIMIT), cyc);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);

    $display("[TB] load aborted while RAM busy");
    applyStimulus(1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 32'h300, 32'h0, RS_FREE,   32'h0);
    applyStimulus(1'b1, 1'b0, 32'h80, 1'b1, 1'b0, 32'h300, 32'h0, RS_BUSY,   32'h0);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h300, 32'h0, RS_BUSY,   32'h0);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h300, 32'h0, RS_FREE,   32'h0);
    applyStimulus(1'b1, 1'b1, 32'h80, 1'b0, 1'b0, 32'h300, 32'h0, RS_ACCESS, 32'h33330000);
    applyStimulus(1'b1, 1'b0, 32'h80, 1'b0, 1'b0, 32'h300, 32'h0, RS_FREE,   32'h0);

    $display("[TB] store completing with a RAM error");
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 32'hDEADBEEF, RS_FREE,  32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h400, 32'hDEADBEEF, RS_ERROR, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h400, 32'hDEADBEEF, RS_FREE,  32'h0);

    $display("[TB] randomized traffic");
    r_ia = 32'h1000;
    r_da = 32'h2000;
    for (int n = 0; n < 1200; n++) begin
      r_rst  = ($urandom_range(0, 49) != 0);
      r_iren = ($urandom_range(0, 9) < 6);
      sel    = $urandom_range(0, 9);
      r_dren = (sel >= 4 && sel < 7);
      r_dwen = (sel >= 7);
      sel    = $urandom_range(0, 9);
      r_rs   = (sel < 2) ? RS_FREE : (sel < 5) ? RS_BUSY : (sel < 9) ? RS_ACCESS : RS_ERROR;
      if ($urandom_range(0, 3) == 0) r_ia = $urandom;
      if ($urandom_range(0, 3) == 0) r_da = $urandom;
      applyStimulus(r_rst, r_iren, r_ia, r_dren, r_dwen, r_da, $urandom, r_rs, $urandom);
    end

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, RS_FREE, 32'h0);
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) begin
      @(negedge CLK);
    end
    #1;
    checkOutput("scoreboard_drain", 128'(exp_q.size()), 128'(0), cyc);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
